uncached_access_unit: RTL and testbench

//  Handles uncached data accesses between the CPU memory stage and the uncached

---
 rtl/uncached_access_unit_if.sv | 56 +++++
 rtl/uncached_access_unit.sv | 152 +++++++++++++++
 tb/tb_uncached_access_unit.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uncached_access_unit_if.sv
// uncached_access_unit_if
//   Bundles the CPU-side uncached load/store/sync signals and the uncached
//   read/write channel towards the cache/AXI interface. Signal names keep
//   their _i/_o suffixes as seen from the access unit.
//   CPU side : rreq_i, raddr_i, rdata_o, rvalid_o, wreq_i, waddr_i, wdata_i,
//              wsel_i, sync_i, stall_o, wbuf_cnt_o
//   Mem side : mem_rreq_o, mem_raddr_o, mem_rvalid_i, mem_rdata_i,
//              mem_wreq_o, mem_waddr_o, mem_wdata_o, mem_wsel_o, mem_bvalid_i
//   Modports : slave  - the access unit itself
//              master - the environment (CPU stage + memory interface)
interface uncached_access_unit_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WBUF_DEPTH = 4
);
    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

    // CPU memory stage
    logic              rreq_i;
    logic [ADDR_W-1:0] raddr_i;
    logic [DATA_W-1:0] rdata_o;
    logic              rvalid_o;
    logic              wreq_i;
    logic [ADDR_W-1:0] waddr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [SEL_W-1:0]  wsel_i;
    logic              sync_i;
    logic              stall_o;
    logic [CNT_W-1:0]  wbuf_cnt_o;

    // uncached channels of the cache/AXI interface
    logic              mem_rreq_o;
    logic [ADDR_W-1:0] mem_raddr_o;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_wreq_o;
    logic [ADDR_W-1:0] mem_waddr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [SEL_W-1:0]  mem_wsel_o;
    logic              mem_bvalid_i;

    modport slave (
        input  rreq_i, raddr_i, wreq_i, waddr_i, wdata_i, wsel_i, sync_i,
               mem_rvalid_i, mem_rdata_i, mem_bvalid_i,
        output rdata_o, rvalid_o, stall_o, wbuf_cnt_o,
               mem_rreq_o, mem_raddr_o, mem_wreq_o, mem_waddr_o, mem_wdata_o, mem_wsel_o
    );

    modport master (
        output rreq_i, raddr_i, wreq_i, waddr_i, wdata_i, wsel_i, sync_i,
               mem_rvalid_i, mem_rdata_i, mem_bvalid_i,
        input  rdata_o, rvalid_o, stall_o, wbuf_cnt_o,
               mem_rreq_o, mem_raddr_o, mem_wreq_o, mem_waddr_o, mem_wdata_o, mem_wsel_o
    );
endinterface

// File: rtl/uncached_access_unit.sv
// uncached_access_unit
//   Uncached data access path between the CPU memory stage and the uncached
//   channels of the cache/AXI interface. Stores go into a posted-write FIFO
//   and retire immediately; the write FSM drains the FIFO one entry at a time
//   with a one-cycle gap after each write response. Loads and SYNC wait for
//   the FIFO to drain so MMIO accesses stay in program order.
//   Ports:
//     clk  - clock, all state on the rising edge
//     rst  - asynchronous reset, active low (0 = reset)
//     bus  - uncached_access_unit_if.slave (CPU side + memory side signals)
module uncached_access_unit #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    uncached_access_unit_if.slave  bus
);
    localparam int SEL_W = DATA_W / 8;
    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(WBUF_DEPTH);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_REQ  = 2'd1;
    localparam logic [1:0] W_GAP  = 2'd2;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_DRAIN = 2'd1;
    localparam logic [1:0] R_REQ   = 2'd2;
    localparam logic [1:0] R_DONE  = 2'd3;

    logic [ADDR_W-1:0] fifo_addr [WBUF_DEPTH];
    logic [DATA_W-1:0] fifo_data [WBUF_DEPTH];
    logic [SEL_W-1:0]  fifo_sel  [WBUF_DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [1:0]        w_state;
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] raddr_q;
    logic [DATA_W-1:0] rdata_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic w_req;
    logic r_req;
    logic drained;
    logic stall_raw;

    // full/empty come from the registered count: a pop this cycle does not
    // make room for a push in the same cycle.
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign push    = bus.wreq_i && !full;
    assign w_req   = (w_state == W_REQ);
    assign r_req   = (r_state == R_REQ);
    assign pop     = w_req && bus.mem_bvalid_i;
    assign drained = empty && (w_state == W_IDLE);

    // Write buffer storage: data only, never reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.waddr_i;
            fifo_data[wr_ptr] <= bus.wdata_i;
            fifo_sel[wr_ptr]  <= bus.wsel_i;
        end
    end

    // Write buffer pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Write FSM. Leaving W_IDLE is held off while a read is on the bus, so
    // a store pushed behind an outstanding load can never overlap it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state <= W_IDLE;
        end else begin
            case (w_state)
                W_IDLE:  if (!empty && !r_req) w_state <= W_REQ;
                W_REQ:   if (bus.mem_bvalid_i) w_state <= W_GAP;
                W_GAP:   w_state <= empty ? W_IDLE : W_REQ;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM. A store pushed in the same cycle as the load request is not
    // yet visible in count, so it is excluded explicitly to keep the load
    // ordered behind it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
        end else begin
            case (r_state)
                R_IDLE:  if (bus.rreq_i) r_state <= (drained && !push) ? R_REQ : R_DRAIN;
                R_DRAIN: if (drained) r_state <= R_REQ;
                R_REQ: begin
                    if (bus.mem_rvalid_i) begin
                        rdata_q <= bus.mem_rdata_i;
                        r_state <= R_DONE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Load address, latched on leaving R_IDLE
    always_ff @(posedge clk) begin
        if ((r_state == R_IDLE) && bus.rreq_i) raddr_q <= bus.raddr_i;
    end

    assign stall_raw = (bus.wreq_i && full)
                     || (bus.rreq_i && (r_state == R_IDLE))
                     || (r_state == R_DRAIN)
                     || r_req
                     || (bus.sync_i && !drained);

    // Gated by rst so the stall output is also 0 while reset is held,
    // even if the CPU keeps a request asserted.
    assign bus.stall_o     = rst && stall_raw;
    assign bus.rvalid_o    = (r_state == R_DONE);
    assign bus.rdata_o     = rdata_q;
    assign bus.wbuf_cnt_o  = count;

    assign bus.mem_rreq_o  = r_req;
    assign bus.mem_raddr_o = r_req ? raddr_q : '0;

    assign bus.mem_wreq_o  = w_req;
    assign bus.mem_waddr_o = w_req ? fifo_addr[rd_ptr] : '0;
    assign bus.mem_wdata_o = w_req ? fifo_data[rd_ptr] : '0;
    assign bus.mem_wsel_o  = w_req ? fifo_sel[rd_ptr]  : '0;
endmodule

// File: tb/tb_uncached_access_unit.sv
// tb_uncached_access_unit
//   Directed scenarios followed by a randomized program of stores, loads and
//   SYNCs. The reference model is the program order itself: every memory-side
//   transaction must appear in exactly the order the CPU issued it, stores
//   carrying their own address/data/byte-enables, loads returning the data
//   the memory responder handed back.
`timescale 1ns/1ps
module tb_uncached_access_unit;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int WBUF_DEPTH = 4;
    localparam int SEL_W      = DATA_W / 8;

    typedef struct packed {
        logic              is_rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  sel;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;
    bit   auto_b = 1'b0;
    bit   auto_r = 1'b0;
    int   b_wait = 0;
    int   r_wait = 0;
    txn_t obs_q[$];
    txn_t exp_q[$];
    logic [DATA_W-1:0] rd_exp_q[$];

    always #5 clk = ~clk;

    uncached_access_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WBUF_DEPTH(WBUF_DEPTH)) bus ();

    uncached_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WBUF_DEPTH(WBUF_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rvalid"},  bus.rvalid_o,    0);
        chk({tag, "_rdata"},   bus.rdata_o,     0);
        chk({tag, "_stall"},   bus.stall_o,     0);
        chk({tag, "_mrreq"},   bus.mem_rreq_o,  0);
        chk({tag, "_mraddr"},  bus.mem_raddr_o, 0);
        chk({tag, "_mwreq"},   bus.mem_wreq_o,  0);
        chk({tag, "_mwaddr"},  bus.mem_waddr_o, 0);
        chk({tag, "_mwdata"},  bus.mem_wdata_o, 0);
        chk({tag, "_mwsel"},   bus.mem_wsel_o,  0);
        chk({tag, "_cnt"},     bus.wbuf_cnt_o,  0);
    endtask

    // One clock: log any completed memory transaction, then play the memory
    // responder for the new cycle.
    task automatic tick();
        logic pb, pr;
        txn_t wt, rt;
        pb = bus.mem_bvalid_i && bus.mem_wreq_o;
        pr = bus.mem_rvalid_i && bus.mem_rreq_o;
        wt.is_rd = 1'b0; wt.addr = bus.mem_waddr_o; wt.data = bus.mem_wdata_o; wt.sel = bus.mem_wsel_o;
        rt.is_rd = 1'b1; rt.addr = bus.mem_raddr_o; rt.data = '0;              rt.sel = '0;
        @(posedge clk);
        #1;
        if (rst && pb) obs_q.push_back(wt);
        if (rst && pr) obs_q.push_back(rt);
        bus.mem_bvalid_i = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        chk("rd_wr_exclusive", bus.mem_rreq_o && bus.mem_wreq_o, 0);
        if (auto_b && bus.mem_wreq_o) begin
            if (b_wait == 0) begin
                bus.mem_bvalid_i = 1'b1;
                b_wait = $urandom_range(0, 3);
            end else b_wait--;
        end
        if (auto_r && bus.mem_rreq_o) begin
            if (r_wait == 0) begin
                bus.mem_rvalid_i = 1'b1;
                bus.mem_rdata_i  = $urandom;
                rd_exp_q.push_back(bus.mem_rdata_i);
                r_wait = $urandom_range(0, 4);
            end else r_wait--;
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output int waited);
        txn_t t;
        waited = 0;
        bus.wreq_i = 1'b1; bus.waddr_i = a; bus.wdata_i = d; bus.wsel_i = s;
        #1;
        while (bus.stall_o && waited < 200) begin
            tick();
            #1;
            waited++;
        end
        chk("store_accepted", waited < 200, 1);
        tick();
        bus.wreq_i = 1'b0;
        t.is_rd = 1'b0; t.addr = a; t.data = d; t.sel = s;
        exp_q.push_back(t);
    endtask

    task automatic do_load(input logic [31:0] a);
        txn_t t;
        int n;
        logic [DATA_W-1:0] ed;
        bus.rreq_i = 1'b1; bus.raddr_i = a;
        t.is_rd = 1'b1; t.addr = a; t.data = '0; t.sel = '0;
        exp_q.push_back(t);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.rvalid_o && n < 300);
        chk("ld_done", bus.rvalid_o, 1);
        if (rd_exp_q.size() > 0) ed = rd_exp_q.pop_front();
        else ed = 'x;
        chk("ld_data", bus.rdata_o, ed);
        bus.rreq_i = 1'b0;
    endtask

    task automatic do_sync();
        int n;
        bus.sync_i = 1'b1;
        #1;
        n = 0;
        while (bus.stall_o && n < 300) begin
            tick();
            #1;
            n++;
        end
        chk("sync_release", n < 300, 1);
        chk("sync_cnt", bus.wbuf_cnt_o, 0);
        chk("sync_all_done", obs_q.size(), exp_q.size());
        tick();
        bus.sync_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((bus.wbuf_cnt_o != 0 || bus.mem_wreq_o) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_done", n < 300, 1);
        tick();
        tick();
    endtask

    task automatic compare_logs(input string tag);
        chk({tag, "_len"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk({tag, "_kind_addr"}, {obs_q[i].is_rd, obs_q[i].addr}, {exp_q[i].is_rd, exp_q[i].addr});
            chk({tag, "_data_sel"},  {obs_q[i].data, obs_q[i].sel},   {exp_q[i].data, exp_q[i].sel});
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int   w;
        int   op;
        logic [31:0] a, d;
        txn_t t;

        rst = 1'b0;
        bus.rreq_i = 1'b0; bus.raddr_i = '0; bus.wreq_i = 1'b0; bus.waddr_i = '0;
        bus.wdata_i = '0; bus.wsel_i = '0; bus.sync_i = 1'b0;
        bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0; bus.mem_bvalid_i = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Scenario 1: load with empty buffer, response 5 cycles later
        obs_q.delete(); exp_q.delete();
        bus.rreq_i = 1'b1; bus.raddr_i = 32'hBFAF_8000;
        #1;
        chk("t1_stall_c0", bus.stall_o, 1);
        chk("t1_no_rreq_c0", bus.mem_rreq_o, 0);
        tick();
        chk("t1_rreq_c1", bus.mem_rreq_o, 1);
        chk("t1_raddr", bus.mem_raddr_o, 32'hBFAF_8000);
        chk("t1_stall_c1", bus.stall_o, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_wait_stall", bus.stall_o, 1);
            chk("t1_wait_rvalid", bus.rvalid_o, 0);
        end
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1234_5678;
        tick();
        chk("t1_rvalid", bus.rvalid_o, 1);
        chk("t1_rdata", bus.rdata_o, 32'h1234_5678);
        chk("t1_done_no_stall", bus.stall_o, 0);
        bus.rreq_i = 1'b0;
        tick();
        chk("t1_rvalid_pulse", bus.rvalid_o, 0);
        chk("t1_rdata_hold", bus.rdata_o, 32'h1234_5678);
        chk("t1_idle_stall", bus.stall_o, 0);

        // Scenario 2: fill DEPTH=4 with bvalid withheld, 5th store stalls
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            do_store(32'h1000_0000 + 32'(i * 4), $urandom, 4'hF, w);
            chk("t2_no_stall", w, 0);
        end
        chk("t2_cnt4", bus.wbuf_cnt_o, 4);
        chk("t2_wreq", bus.mem_wreq_o, 1);
        chk("t2_head", bus.mem_waddr_o, 32'h1000_0000);
        d = $urandom;
        bus.wreq_i = 1'b1; bus.waddr_i = 32'h1000_0010; bus.wdata_i = d; bus.wsel_i = 4'h3;
        #1;
        chk("t2_full_stall", bus.stall_o, 1);
        tick();
        #1;
        chk("t2_full_stall2", bus.stall_o, 1);
        chk("t2_cnt_still4", bus.wbuf_cnt_o, 4);
        bus.mem_bvalid_i = 1'b1;
        tick();
        #1;
        chk("t2_cnt_pop", bus.wbuf_cnt_o, 3);
        chk("t2_accept_no_stall", bus.stall_o, 0);
        tick();
        bus.wreq_i = 1'b0;
        t.is_rd = 1'b0; t.addr = 32'h1000_0010; t.data = d; t.sel = 4'h3;
        exp_q.push_back(t);
        chk("t2_cnt_refill", bus.wbuf_cnt_o, 4);
        auto_b = 1'b1;
        drain();
        auto_b = 1'b0;
        compare_logs("t2");

        // Scenario 3: store then immediate load, read waits for bvalid + gap
        do_store(32'hBFD0_0000, 32'h0000_000A, 4'hF, w);
        bus.rreq_i = 1'b1; bus.raddr_i = 32'hBFD0_0010;
        t.is_rd = 1'b1; t.addr = 32'hBFD0_0010; t.data = '0; t.sel = '0;
        exp_q.push_back(t);
        tick();
        chk("t3_drain_no_rreq", bus.mem_rreq_o, 0);
        chk("t3_wreq", bus.mem_wreq_o, 1);
        chk("t3_stall", bus.stall_o, 1);
        tick();
        chk("t3_drain_no_rreq2", bus.mem_rreq_o, 0);
        bus.mem_bvalid_i = 1'b1;
        tick();
        chk("t3_bvalid_no_rreq", bus.mem_rreq_o, 0);
        chk("t3_gap_no_wreq", bus.mem_wreq_o, 0);
        tick();
        chk("t3_gap_no_rreq", bus.mem_rreq_o, 0);
        tick();
        chk("t3_rreq_rise", bus.mem_rreq_o, 1);
        chk("t3_write_first", obs_q.size(), 1);
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hCAFE_F00D;
        tick();
        chk("t3_rvalid", bus.rvalid_o, 1);
        chk("t3_rdata", bus.rdata_o, 32'hCAFE_F00D);
        bus.rreq_i = 1'b0;
        tick();
        compare_logs("t3");

        // Scenario 4: push+pop at count 2, then wrap with 8 entries
        do_store(32'h2000_0000, $urandom, 4'h1, w);
        do_store(32'h2000_0004, $urandom, 4'h2, w);
        chk("t4_cnt2", bus.wbuf_cnt_o, 2);
        chk("t4_wreq", bus.mem_wreq_o, 1);
        d = $urandom;
        bus.wreq_i = 1'b1; bus.waddr_i = 32'h2000_0008; bus.wdata_i = d; bus.wsel_i = 4'h4;
        bus.mem_bvalid_i = 1'b1;
        #1;
        chk("t4_no_stall", bus.stall_o, 0);
        tick();
        bus.wreq_i = 1'b0;
        t.is_rd = 1'b0; t.addr = 32'h2000_0008; t.data = d; t.sel = 4'h4;
        exp_q.push_back(t);
        chk("t4_cnt_same", bus.wbuf_cnt_o, 2);
        auto_b = 1'b1;
        for (int i = 3; i < 8; i++) do_store(32'h2000_0000 + 32'(i * 4), $urandom, 4'(i), w);
        drain();
        auto_b = 1'b0;
        compare_logs("t4");

        // Scenario 5: SYNC with 3 entries buffered
        for (int i = 0; i < 3; i++) do_store(32'h3000_0000 + 32'(i * 4), $urandom, 4'hF, w);
        chk("t5_cnt3", bus.wbuf_cnt_o, 3);
        bus.sync_i = 1'b1;
        #1;
        chk("t5_stall", bus.stall_o, 1);
        for (int k = 0; k < 3; k++) begin
            int n;
            n = 0;
            while (!bus.mem_wreq_o && n < 20) begin
                tick();
                chk("t5_wait_stall", bus.stall_o, 1);
                n++;
            end
            chk("t5_wreq_seen", bus.mem_wreq_o, 1);
            bus.mem_bvalid_i = 1'b1;
            tick();
            chk("t5_gap_stall", bus.stall_o, 1);
        end
        tick();
        chk("t5_released", bus.stall_o, 0);
        chk("t5_cnt0", bus.wbuf_cnt_o, 0);
        bus.sync_i = 1'b0;
        compare_logs("t5");

        // Scenario 6: async reset during R_REQ with 2 entries buffered
        bus.rreq_i = 1'b1; bus.raddr_i = 32'h1FC0_0000;
        tick();
        chk("t6_rreq", bus.mem_rreq_o, 1);
        bus.wreq_i = 1'b1; bus.waddr_i = 32'h4000_0000; bus.wdata_i = 32'h1111_1111; bus.wsel_i = 4'hF;
        tick();
        bus.waddr_i = 32'h4000_0004; bus.wdata_i = 32'h2222_2222;
        tick();
        bus.wreq_i = 1'b0;
        chk("t6_cnt2", bus.wbuf_cnt_o, 2);
        chk("t6_no_wreq_during_read", bus.mem_wreq_o, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("t6_async");
        bus.rreq_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("t6_post_cnt", bus.wbuf_cnt_o, 0);
        chk("t6_post_rreq", bus.mem_rreq_o, 0);
        chk("t6_post_stall", bus.stall_o, 0);
        tick();
        chk("t6_post_wreq", bus.mem_wreq_o, 0);
        chk("t6_post_rvalid", bus.rvalid_o, 0);
        obs_q.delete(); exp_q.delete(); rd_exp_q.delete();

        // Randomized program against program-order reference
        auto_b = 1'b1; auto_r = 1'b1;
        for (int i = 0; i < 50; i++) begin
            op = $urandom_range(0, 9);
            a  = 32'hA000_0000 | ($urandom & 32'h0000_FFFC);
            if (op < 6)      do_store(a, $urandom, 4'($urandom_range(1, 15)), w);
            else if (op < 9) do_load(a);
            else             do_sync();
        end
        drain();
        compare_logs("rand");
        chk("rand_cnt_empty", bus.wbuf_cnt_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
